div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 170 +++++++++++++++++
 tb/tb_div.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- 32-bit iterative restoring divider for the EX stage.
//
// One shift-subtract step per cycle over 32 cycles. Signed mode divides the
// operand magnitudes and then fixes up the signs. Division by zero skips the
// iteration and returns zero.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   signed_div_i 1 = signed (two's complement), 0 = unsigned
//   opdata1_i    dividend (sampled only when leaving FREE)
//   opdata2_i    divisor  (sampled only when leaving FREE)
//   start_i      division request, held high until the result is consumed
//   annul_i      flush: cancels a division in BYZERO or ON
//   result_o     {remainder, quotient}
//   ready_o      result_o valid
//   busy_o       high whenever the divider is not idle
//   div_zero_o   (only with DIV_ZERO_FLAG_EN) high while ready_o reports
//                a divide-by-zero result
//
// Optional feature macro: DIV_ZERO_FLAG_EN
// -----------------------------------------------------------------------------
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
`ifdef DIV_ZERO_FLAG_EN
  output logic        busy_o,
  output logic        div_zero_o
`else
  output logic        busy_o
`endif
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [5:0]  r_cnt;
  // Partial remainder lives in [64:32], quotient bits shift in at [0].
  logic [64:0] r_work;
  logic [31:0] r_divisor;
  logic        r_signed;
  logic        r_sign1;
  logic        r_sign2;
  logic        r_zero;

  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_diff;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
  assign w_diff = {1'b0, r_work[63:32]} - {1'b0, r_divisor};

  // After the final step the remainder sits one bit higher, in [64:33].
  assign w_quot = (r_signed && (r_sign1 ^ r_sign2)) ? -r_work[31:0]  : r_work[31:0];
  assign w_rem  = (r_signed && r_sign1)             ? -r_work[64:33] : r_work[64:33];

  assign busy_o = (r_state != S_FREE);

`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_o = ready_o & r_zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FREE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FREE: begin
        if (start_i && !annul_i)
          w_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
      end
      S_BYZERO: w_next = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)                 w_next = S_FREE;
        else if (r_cnt == 6'd32)     w_next = S_END;
      end
      S_END: begin
        if (!start_i) w_next = S_FREE;
      end
      default: w_next = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_zero    <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              r_zero <= 1'b1;
            end else begin
              r_zero    <= 1'b0;
              r_cnt     <= '0;
              r_work    <= {32'd0, w_abs1, 1'b0};
              r_divisor <= w_abs2;
              r_signed  <= signed_div_i;
              r_sign1   <= signed_div_i & opdata1_i[31];
              r_sign2   <= signed_div_i & opdata2_i[31];
            end
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            r_work <= '0;
          end
        end
        S_ON: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (r_cnt != 6'd32) begin
            if (w_diff[32]) r_work <= {r_work[63:0], 1'b0};
            else            r_work <= {w_diff[31:0], r_work[31:0], 1'b1};
            r_cnt <= r_cnt + 6'd1;
          end else begin
            // Store the sign-corrected result back in the same layout so that
            // END presents {[64:33], [31:0]} for both the normal and zero path.
            r_work <= {w_rem, 1'b0, w_quot};
            r_cnt  <= '0;
          end
        end
        S_END: begin
          if (start_i) begin
            result_o <= {r_work[64:33], r_work[31:0]};
            ready_o  <= 1'b1;
          end else begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div -- self-checking bench for div. Directed cases plus randomized
// operands compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero_o;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  div u_dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
`ifdef DIV_ZERO_FLAG_EN
    .busy_o       (busy_o),
    .div_zero_o   (div_zero_o)
`else
    .busy_o       (busy_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating division; signed done in 64-bit so that
  // -2^31 / -1 wraps to 0x80000000 rather than overflowing.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint      sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input string tag);
    logic [63:0] exp;
    int unsigned exp_lat;
    int unsigned n;
    exp     = ref_div(a, b, sgn);
    exp_lat = (b == 32'd0) ? 2 : 34;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    tick();
    // operands must be ignored once the division is under way
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    check({tag, "_busy"}, {63'd0, busy_o}, 64'd1);
    n = 0;
    while (!ready_o && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp);
`ifdef DIV_ZERO_FLAG_EN
    check({tag, "_dz"}, {63'd0, div_zero_o}, {63'd0, (b == 32'd0)});
`endif
    tick();
    check({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    @(negedge clk);
    start_i = 1'b0;
    tick();
    check({tag, "_drop"}, {ready_o, busy_o, result_o[61:0]}, 64'd0);
  endtask

  initial begin
    int unsigned hits;
    logic [31:0] ra, rb;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset", {ready_o, busy_o, result_o[61:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(32'd100,        32'd7,        1'b0, "u100_7");
    run_div(32'hFFFFFFF9,   32'd2,        1'b1, "s_m7_2");
    run_div(32'hFFFFFFF9,   32'd2,        1'b0, "u_m7_2");
    run_div(32'h12345678,   32'd0,        1'b0, "byzero");
    run_div(32'h80000000,   32'hFFFFFFFF, 1'b1, "s_min_m1");
    run_div(32'd5,          32'hFFFFFFFD, 1'b1, "s_5_m3");

    // annul during ON
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'h12345678; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    repeat (9) tick();
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    check("annul_on", {ready_o, busy_o, result_o[61:0]}, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    hits = 0;
    repeat (40) begin tick(); if (ready_o) hits++; end
    check("annul_no_ready", 64'(hits), 64'd0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, "after_annul");

    // annul in BYZERO
    @(negedge clk);
    opdata2_i = '0; start_i = 1'b1;
    tick();
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    check("annul_byzero", {ready_o, busy_o, result_o[61:0]}, 64'd0);

    // start with annul in FREE is ignored
    @(negedge clk);
    opdata2_i = 32'd9; start_i = 1'b1; annul_i = 1'b1;
    tick();
    check("annul_free", {62'd0, busy_o, ready_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;

    // reset mid-division
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    tick();
    repeat (19) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_mid", {ready_o, busy_o, result_o[61:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    hits = 0;
    repeat (40) begin tick(); if (ready_o || busy_o) hits++; end
    check("rst_quiet", 64'(hits), 64'd0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = -($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_div(ra, rb, 1'($urandom_range(0, 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
